// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional auto-repeat is enabled with the KEYPAD_REPEAT_EN macro.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;
  localparam int VALUE_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_class_e;

endpackage

// File: rtl/keypad_scan_core.sv
// Column drive, row synchroniser and per-scan snapshot of the key matrix.
// Emits one scan_done pulse per full scan with the scan's classification.
module keypad_scan_core
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 12500
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] rows_n,
  output logic [NUM_COLS-1:0] cols_n,
  output logic                scan_done,
  output scan_class_e         scan_class,
  output logic [CODE_W-1:0]   scan_code
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);

  logic [NUM_ROWS-1:0]          rows_s1_q, rows_s2_q;
  logic [DW-1:0]                dwell_q, dwell_d;
  logic [1:0]                   col_q, col_d;
  logic [NUM_COLS-1:0]          cols_n_q, cols_n_d;
  logic [NUM_ROWS*NUM_COLS-1:0] snap_q, snap_d;
  logic                         scan_done_q, scan_done_d;
  logic                         tick;
  logic [4:0]                   ones;
  logic [CODE_W-1:0]            code_c;

  always_comb begin
    tick        = (dwell_q == DWELL_MAX);
    dwell_d     = tick ? '0 : dwell_q + 1'b1;
    col_d       = col_q;
    cols_n_d    = cols_n_q;
    snap_d      = snap_q;
    scan_done_d = 1'b0;
    if (tick) begin
      // Rows for the driven column have settled through the synchroniser by now.
      for (int r = 0; r < NUM_ROWS; r++)
        snap_d[r*NUM_COLS + int'(col_q)] = ~rows_s2_q[r];
      col_d       = col_q + 2'd1;
      cols_n_d    = {cols_n_q[NUM_COLS-2:0], cols_n_q[NUM_COLS-1]};
      scan_done_d = (col_q == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_s1_q   <= '1;
      rows_s2_q   <= '1;
      dwell_q     <= '0;
      col_q       <= '0;
      cols_n_q    <= 4'b1110;
      snap_q      <= '0;
      scan_done_q <= 1'b0;
    end else begin
      rows_s1_q   <= rows_n;
      rows_s2_q   <= rows_s1_q;
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      cols_n_q    <= cols_n_d;
      snap_q      <= snap_d;
      scan_done_q <= scan_done_d;
    end
  end

  // scan_done trails the final capture by one cycle, so snap_q is whole here.
  always_comb begin
    ones   = '0;
    code_c = '0;
    for (int i = 0; i < NUM_ROWS*NUM_COLS; i++) begin
      ones = ones + {4'b0, snap_q[i]};
      if (snap_q[i]) code_c = CODE_W'(i);
    end
  end

  assign cols_n     = cols_n_q;
  assign scan_done  = scan_done_q;
  assign scan_code  = code_c;
  assign scan_class = (ones == 5'd0) ? NONE : (ones == 5'd1) ? SINGLE : MULTI;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: whole-scan debounce FSM and hex entry register.
// Define KEYPAD_REPEAT_EN to add auto-repeat while a key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV           = 12500,
  parameter int DEBOUNCE_SCANS     = 10,
  parameter int REPEAT_DELAY_SCANS = 500,
  parameter int REPEAT_RATE_SCANS  = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] rows_n,
  input  logic                clear,
  output logic [NUM_COLS-1:0] cols_n,
  output logic                key_valid,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_down,
  output logic [VALUE_W-1:0]  value
);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY_SCANS < 1 ||
      REPEAT_RATE_SCANS < 1) begin : g_param_chk
    $error("keypad_scanner: illegal parameter value");
  end

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_SCANS - 1);

  logic              scan_done;
  scan_class_e       scan_class;
  logic [CODE_W-1:0] scan_code;

  keypad_scan_core #(.SCAN_DIV(SCAN_DIV)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .rows_n     (rows_n),
    .cols_n     (cols_n),
    .scan_done  (scan_done),
    .scan_class (scan_class),
    .scan_code  (scan_code)
  );

  kp_state_e          state_q, state_d;
  logic [CODE_W-1:0]  cand_q, cand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               key_valid_q, key_valid_d;
  logic [CODE_W-1:0]  key_code_q, key_code_d;
  logic [VALUE_W-1:0] value_q, value_d;
  logic               accept;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY_SCANS + REPEAT_RATE_SCANS + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY_SCANS);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_DELAY_SCANS + REPEAT_RATE_SCANS);
  logic [RW-1:0] rep_q, rep_d, rep_inc;
`endif

  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    value_d     = value_q;
    key_valid_d = 1'b0;
    accept      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
    rep_inc     = rep_q + 1'b1;
`endif
    if (scan_done) begin
      case (state_q)
        IDLE: if (scan_class == SINGLE) begin
          cand_d = scan_code;
          cnt_d  = CW'(1);
          if (DEBOUNCE_SCANS == 1) begin
            accept  = 1'b1;
            state_d = HELD;
          end else begin
            state_d = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (scan_class == SINGLE && scan_code == cand_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DB_LAST) begin
              accept  = 1'b1;
              state_d = HELD;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (scan_class == NONE) begin
            cnt_d   = CW'(1);
            state_d = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE_DB;
          end
`ifdef KEYPAD_REPEAT_EN
          // Any key present (even ambiguous) keeps the hold and its repeat timer.
          else begin
            rep_d = rep_inc;
            if (rep_inc == REP_FIRST) accept = 1'b1;
            if (rep_inc == REP_NEXT) begin
              accept = 1'b1;
              rep_d  = REP_FIRST;
            end
          end
`endif
        end
        RELEASE_DB: begin
          if (scan_class == NONE) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == DB_LAST) state_d = IDLE;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if (state_d == IDLE) rep_d = '0;
`endif
    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = cand_d;
      value_d     = {value_q[VALUE_W-CODE_W-1:0], cand_d};
    end
    if (clear) value_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      value_q     <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      value_q     <= value_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign value     = value_q;
  assign key_down  = (state_q == HELD) || (state_q == RELEASE_DB);

endmodule
